// File: rtl/vending_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHANGE  = 2'd2,
        VEND    = 2'd3
    } state_e;

    localparam logic [2:0] COIN_NONE = 3'd0;
    localparam logic [2:0] COIN_1    = 3'd1;
    localparam logic [2:0] COIN_2    = 3'd2;
    localparam logic [2:0] COIN_5    = 3'd5;

    function automatic logic coin_legal(input logic [2:0] code);
        return (code == COIN_1) || (code == COIN_2) || (code == COIN_5);
    endfunction

endpackage

// File: rtl/vending_if.sv
// Coin-acceptor inputs and dispenser/hopper outputs of the vending controller.
interface vending_if;
    logic [2:0] coin;
    logic       cancel;
    logic       coffee;
    logic [2:0] rem;
    logic       busy;
    logic       coin_reject;

    modport master (output coin, cancel, input coffee, rem, busy, coin_reject);
    modport slave  (input coin, cancel, output coffee, rem, busy, coin_reject);
endinterface

// File: rtl/vending_change.sv
// Splits an amount into one bounded change chunk and the remainder still owed.
module vending_change #(
    parameter int CREDIT_W = 4,
    parameter int MAX_CHG  = 2
) (
    input  logic [CREDIT_W-1:0] amount_i,
    output logic [CREDIT_W-1:0] chunk_o,
    output logic [CREDIT_W-1:0] rest_o
);
    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CHG);

    assign chunk_o = (amount_i > MAX_C) ? MAX_C : amount_i;
    assign rest_o  = amount_i - chunk_o;
endmodule

// File: rtl/vending_ctrl_p.sv
// Coin vending controller: credit accumulation, bounded change payout, refund, vend.
// state   | meaning
// IDLE    | no credit held
// COLLECT | 0 < credit < PRICE
// CHANGE  | paying chg_left out; refund_q picks vend or abort afterwards
// VEND    | coffee pulse cycle
module vending_ctrl_p
    import vending_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int MAX_CHG  = 2,
    parameter int CREDIT_W = 4
) (
    input  logic     clk,
    input  logic     firstinit,
    vending_if.slave bus
);
    if (PRICE < 1 || PRICE > 15 || MAX_CHG < 1 || MAX_CHG > 7 ||
        CREDIT_W < 3 || CREDIT_W > 30 || (2 ** CREDIT_W) <= PRICE + 4) begin : g_bad_param
        $error("vending_ctrl_p: illegal PRICE/MAX_CHG/CREDIT_W combination");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] chg_left_q;
    logic                refund_q;
    logic                coffee_q;
    logic                reject_q;
    logic [2:0]          rem_q;

    logic [CREDIT_W-1:0] coin_w;
    logic [CREDIT_W-1:0] sum;
    logic [CREDIT_W-1:0] excess;
    logic [CREDIT_W-1:0] chg_in;
    logic [CREDIT_W-1:0] chunk;
    logic [CREDIT_W-1:0] rest;
    logic                cancel_hit;
    logic                coin_nz;

    assign coin_w     = CREDIT_W'(bus.coin);
    assign sum        = credit_q + coin_w;
    assign excess     = sum - PRICE_C;
    assign coin_nz    = (bus.coin != COIN_NONE);
    assign cancel_hit = (state_q == COLLECT) && bus.cancel;

    // One splitter serves overpay, refund and ongoing payout; the state picks its input.
    assign chg_in = (state_q == CHANGE) ? chg_left_q :
                    cancel_hit          ? credit_q   : excess;

    vending_change #(
        .CREDIT_W (CREDIT_W),
        .MAX_CHG  (MAX_CHG)
    ) u_change (
        .amount_i (chg_in),
        .chunk_o  (chunk),
        .rest_o   (rest)
    );

    always_ff @(posedge clk) begin
        if (firstinit) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            chg_left_q <= '0;
            refund_q   <= 1'b0;
            coffee_q   <= 1'b0;
            reject_q   <= 1'b0;
            rem_q      <= 3'd0;
        end else begin
            coffee_q <= 1'b0;
            reject_q <= 1'b0;
            rem_q    <= 3'd0;
            case (state_q)
                IDLE, COLLECT: begin
                    if (cancel_hit) begin
                        reject_q   <= coin_nz;
                        rem_q      <= 3'(chunk);
                        chg_left_q <= rest;
                        refund_q   <= 1'b1;
                        credit_q   <= '0;
                        state_q    <= CHANGE;
                    end else if (coin_legal(bus.coin)) begin
                        if (sum < PRICE_C) begin
                            credit_q <= sum;
                            state_q  <= COLLECT;
                        end else if (sum == PRICE_C) begin
                            coffee_q <= 1'b1;
                            credit_q <= '0;
                            state_q  <= VEND;
                        end else begin
                            rem_q      <= 3'(chunk);
                            chg_left_q <= rest;
                            refund_q   <= 1'b0;
                            credit_q   <= '0;
                            state_q    <= CHANGE;
                        end
                    end else if (coin_nz) begin
                        reject_q <= 1'b1;
                    end
                end
                CHANGE: begin
                    reject_q <= coin_nz;
                    if (chg_left_q != '0) begin
                        rem_q      <= 3'(chunk);
                        chg_left_q <= rest;
                    end else if (!refund_q) begin
                        coffee_q <= 1'b1;
                        state_q  <= VEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                VEND: begin
                    reject_q <= coin_nz;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.coffee      = coffee_q;
    assign bus.rem         = rem_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = (state_q == CHANGE) || (state_q == VEND);
endmodule

// File: tb/tb_vending_ctrl_p.sv
// Scoreboard bench: three parameterisations driven in lockstep against a behavioural model.
module tb_vending_ctrl_p;
    import vending_pkg::*;

    logic clk = 1'b0;
    logic firstinit = 1'b0;
    always #5 clk = ~clk;

    vending_if if0 ();
    vending_if if1 ();
    vending_if if2 ();

    vending_ctrl_p #(.PRICE(3), .MAX_CHG(2), .CREDIT_W(4)) u_dut0 (.clk(clk), .firstinit(firstinit), .bus(if0));
    vending_ctrl_p #(.PRICE(3), .MAX_CHG(1), .CREDIT_W(4)) u_dut1 (.clk(clk), .firstinit(firstinit), .bus(if1));
    vending_ctrl_p #(.PRICE(9), .MAX_CHG(3), .CREDIT_W(4)) u_dut2 (.clk(clk), .firstinit(firstinit), .bus(if2));

    typedef struct {int st; int credit; int chg; int refund;} mdl_t;
    typedef struct {int coffee; int rem; int busy; int rej;} exp_t;
    typedef struct {int coin; int cancel; int rst;} stim_t;

    int    prices[3]  = '{3, 3, 9};
    int    maxchg[3]  = '{2, 1, 3};
    mdl_t  mdl[3];
    exp_t  sbq0[$];
    exp_t  sbq1[$];
    exp_t  sbq2[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // st: 0 idle, 1 collect, 2 change, 3 vend
    task automatic model_step(input mdl_t mi, input int price, input int mc, input int coin,
                              input int cancel, input int rst, output mdl_t mo, output exp_t o);
        int s;
        int amt;
        bit legal;
        mo = mi;
        o = '{0, 0, 0, 0};
        legal = (coin == 1) || (coin == 2) || (coin == 5);
        if (rst != 0) begin
            mo = '{0, 0, 0, 0};
        end else if (mi.st == 0 || mi.st == 1) begin
            if (mi.st == 1 && cancel != 0) begin
                o.rej     = (coin != 0);
                amt       = (mi.credit < mc) ? mi.credit : mc;
                o.rem     = amt;
                mo.chg    = mi.credit - amt;
                mo.refund = 1;
                mo.credit = 0;
                mo.st     = 2;
            end else if (legal) begin
                s = mi.credit + coin;
                if (s < price) begin
                    mo.credit = s;
                    mo.st     = 1;
                end else if (s == price) begin
                    o.coffee  = 1;
                    mo.credit = 0;
                    mo.st     = 3;
                end else begin
                    amt       = (s - price < mc) ? s - price : mc;
                    o.rem     = amt;
                    mo.chg    = s - price - amt;
                    mo.refund = 0;
                    mo.credit = 0;
                    mo.st     = 2;
                end
            end else if (coin != 0) begin
                o.rej = 1;
            end
        end else if (mi.st == 2) begin
            o.rej = (coin != 0);
            if (mi.chg > 0) begin
                amt    = (mi.chg < mc) ? mi.chg : mc;
                o.rem  = amt;
                mo.chg = mi.chg - amt;
            end else if (mi.refund == 0) begin
                o.coffee = 1;
                mo.st    = 3;
            end else begin
                mo.st = 0;
            end
        end else begin
            o.rej = (coin != 0);
            mo.st = 0;
        end
        o.busy = (mo.st == 2 || mo.st == 3);
    endtask

    task automatic compare_dut(input int idx);
        exp_t e;
        exp_t ob;
        bit   empty;
        empty = 1'b0;
        case (idx)
            0: begin
                ob = '{int'(if0.coffee), int'(if0.rem), int'(if0.busy), int'(if0.coin_reject)};
                if (sbq0.size() == 0) empty = 1'b1; else e = sbq0.pop_front();
            end
            1: begin
                ob = '{int'(if1.coffee), int'(if1.rem), int'(if1.busy), int'(if1.coin_reject)};
                if (sbq1.size() == 0) empty = 1'b1; else e = sbq1.pop_front();
            end
            default: begin
                ob = '{int'(if2.coffee), int'(if2.rem), int'(if2.busy), int'(if2.coin_reject)};
                if (sbq2.size() == 0) empty = 1'b1; else e = sbq2.pop_front();
            end
        endcase
        if (empty) begin
            check_val($sformatf("dut%0d_sb_empty", idx), 1, 0);
        end else begin
            check_val($sformatf("dut%0d_coffee", idx), ob.coffee, e.coffee);
            check_val($sformatf("dut%0d_rem", idx), ob.rem, e.rem);
            check_val($sformatf("dut%0d_busy", idx), ob.busy, e.busy);
            check_val($sformatf("dut%0d_coin_reject", idx), ob.rej, e.rej);
        end
    endtask

    task automatic drive(input int coin, input int cancel, input int rst);
        mdl_t nm;
        exp_t e;
        if0.coin = 3'(coin); if1.coin = 3'(coin); if2.coin = 3'(coin);
        if0.cancel = cancel[0]; if1.cancel = cancel[0]; if2.cancel = cancel[0];
        firstinit = rst[0];
        for (int i = 0; i < 3; i++) begin
            model_step(mdl[i], prices[i], maxchg[i], coin, cancel, rst, nm, e);
            mdl[i] = nm;
            case (i)
                0: sbq0.push_back(e);
                1: sbq1.push_back(e);
                default: sbq2.push_back(e);
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) compare_dut(i);
    endtask

    stim_t dir[$];
    int    coins[6] = '{0, 1, 2, 5, 3, 7};

    initial begin
        for (int i = 0; i < 3; i++) mdl[i] = '{0, 0, 0, 0};
        if0.coin = 3'd0; if1.coin = 3'd0; if2.coin = 3'd0;
        if0.cancel = 1'b0; if1.cancel = 1'b0; if2.cancel = 1'b0;
        @(negedge clk);
        dir = '{
            '{0, 0, 1},
            '{5, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{0, 0, 1},
            '{1, 0, 0}, '{1, 0, 0}, '{1, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{0, 0, 1},
            '{2, 0, 0}, '{5, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{0, 0, 1},
            '{2, 0, 0}, '{1, 1, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{1, 1, 0}, '{0, 1, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{3, 0, 0}, '{7, 0, 0}, '{0, 0, 0},
            '{2, 0, 0}, '{5, 0, 0}, '{1, 0, 0}, '{7, 1, 0}, '{2, 0, 0},
            '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
            '{5, 0, 0}, '{0, 0, 1}, '{0, 0, 0}, '{0, 0, 0},
            '{5, 0, 0}, '{5, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}
        };
        foreach (dir[k]) drive(dir[k].coin, dir[k].cancel, dir[k].rst);
        for (int k = 0; k < 400; k++) begin
            drive(coins[$urandom_range(5)],
                  ($urandom_range(5) == 0) ? 1 : 0,
                  ($urandom_range(49) == 0) ? 1 : 0);
        end
        check_val("sb_leftover", sbq0.size() + sbq1.size() + sbq2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
